// File: rtl/sad_pipe_pkg.sv
// Shared definitions for the IF-ID-EX-MEM-SAD1-SAD2-SAD3-WB pipeline hazard logic.
package sad_pipe_pkg;

  localparam int unsigned REG_IDX_W        = 5;
  localparam int unsigned NUM_REGS         = 32;
  localparam int unsigned LOAD_LAT_DEFAULT = 1;
  localparam int unsigned SAD_LAT_DEFAULT  = 4;

  typedef enum logic [2:0] {
    FWD_REGFILE = 3'd0,
    FWD_MEM     = 3'd1,
    FWD_SAD1    = 3'd2,
    FWD_SAD2    = 3'd3,
    FWD_SAD3    = 3'd4
  } fwdSel_e;

endpackage

// File: rtl/fwd_select.sv
// Priority forward-source selector for one EX operand (youngest producing stage wins).
module fwd_select
  import sad_pipe_pkg::*;
(
  input  logic                 exValid,
  input  logic [REG_IDX_W-1:0] src,
  input  logic [REG_IDX_W-1:0] memRd,
  input  logic                 memRegWrite,
  input  logic [REG_IDX_W-1:0] sad1Rd,
  input  logic                 sad1RegWrite,
  input  logic [REG_IDX_W-1:0] sad2Rd,
  input  logic                 sad2RegWrite,
  input  logic [REG_IDX_W-1:0] sad3Rd,
  input  logic                 sad3RegWrite,
  output logic [2:0]           fwd
);

  fwdSel_e sel;

  always_comb begin
    sel = FWD_REGFILE;
    // r0 is hardwired, so a match on it must never forward.
    if (exValid && (src != '0)) begin
      if (memRegWrite && (memRd == src)) begin
        sel = FWD_MEM;
      end else if (sad1RegWrite && (sad1Rd == src)) begin
        sel = FWD_SAD1;
      end else if (sad2RegWrite && (sad2Rd == src)) begin
        sel = FWD_SAD2;
      end else if (sad3RegWrite && (sad3Rd == src)) begin
        sel = FWD_SAD3;
      end
    end
  end

  assign fwd = sel;

endmodule

// File: rtl/sad_hazard_scoreboard.sv
// Hazard scoreboard and EX forwarding control for the SAD-extended MIPS pipeline.
// Optional stall counter output enabled by defining SAD_STALL_COUNT_EN.
module sad_hazard_scoreboard
  import sad_pipe_pkg::*;
#(
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEFAULT,
  parameter int unsigned SAD_LAT  = SAD_LAT_DEFAULT,
  parameter int unsigned CNT_W    = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 IdValid,
  input  logic [REG_IDX_W-1:0] IdRs,
  input  logic [REG_IDX_W-1:0] IdRt,
  input  logic                 IdRsUsed,
  input  logic                 IdRtUsed,
  input  logic [REG_IDX_W-1:0] IdRd,
  input  logic                 IdRegWrite,
  input  logic                 IdIsLoad,
  input  logic                 IdIsSAD,
  input  logic                 Flush,
  input  logic [REG_IDX_W-1:0] MEMrd,
  input  logic [REG_IDX_W-1:0] SAD1rd,
  input  logic [REG_IDX_W-1:0] SAD2rd,
  input  logic [REG_IDX_W-1:0] SAD3rd,
  input  logic                 MEMRegWrite,
  input  logic                 SAD1RegWrite,
  input  logic                 SAD2RegWrite,
  input  logic                 SAD3RegWrite,
`ifdef SAD_STALL_COUNT_EN
  output logic [31:0]          StallCount,
`endif
  output logic                 Stall,
  output logic                 Issue,
  output logic [2:0]           FwdA,
  output logic [2:0]           FwdB
);

  logic [CNT_W-1:0]     cntQ [NUM_REGS-1:1];
  logic [CNT_W-1:0]     cntD [NUM_REGS-1:1];
  logic [NUM_REGS-1:0]  busy;
  logic                 rawA, rawB, waw, hazard;
  logic                 exValidQ;
  logic [REG_IDX_W-1:0] exRsQ, exRtQ;
  logic [CNT_W-1:0]     issueLat;

  always_comb begin
    busy    = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy[i] = (cntQ[i] != '0);
    end
  end

  // busy[0] is constant zero, so r0 needs no separate exclusion here.
  assign rawA   = IdRsUsed && busy[IdRs];
  assign rawB   = IdRtUsed && busy[IdRt];
  assign waw    = IdRegWrite && busy[IdRd];
  assign hazard = rawA || rawB || waw;

  assign Stall  = IdValid && !Flush && hazard;
  assign Issue  = IdValid && !Flush && !hazard;

  assign issueLat = IdIsSAD  ? CNT_W'(SAD_LAT)  :
                    IdIsLoad ? CNT_W'(LOAD_LAT) : '0;

  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      cntD[i] = (cntQ[i] != '0) ? cntQ[i] - 1'b1 : cntQ[i];
      if (Issue && IdRegWrite && (IdRd == REG_IDX_W'(i))) begin
        cntD[i] = issueLat;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        cntQ[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        cntQ[i] <= cntD[i];
      end
    end
  end

  // Unused sources are stored as r0 so they can never pick up a forward.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      exValidQ <= 1'b0;
      exRsQ    <= '0;
      exRtQ    <= '0;
    end else begin
      exValidQ <= Issue;
      exRsQ    <= IdRsUsed ? IdRs : '0;
      exRtQ    <= IdRtUsed ? IdRt : '0;
    end
  end

  fwd_select u_fwdA (
    .exValid      (exValidQ),
    .src          (exRsQ),
    .memRd        (MEMrd),
    .memRegWrite  (MEMRegWrite),
    .sad1Rd       (SAD1rd),
    .sad1RegWrite (SAD1RegWrite),
    .sad2Rd       (SAD2rd),
    .sad2RegWrite (SAD2RegWrite),
    .sad3Rd       (SAD3rd),
    .sad3RegWrite (SAD3RegWrite),
    .fwd          (FwdA)
  );

  fwd_select u_fwdB (
    .exValid      (exValidQ),
    .src          (exRtQ),
    .memRd        (MEMrd),
    .memRegWrite  (MEMRegWrite),
    .sad1Rd       (SAD1rd),
    .sad1RegWrite (SAD1RegWrite),
    .sad2Rd       (SAD2rd),
    .sad2RegWrite (SAD2RegWrite),
    .sad3Rd       (SAD3rd),
    .sad3RegWrite (SAD3RegWrite),
    .fwd          (FwdB)
  );

`ifdef SAD_STALL_COUNT_EN
  logic [31:0] stallCountQ;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stallCountQ <= '0;
    end else if (Stall && (stallCountQ != 32'hFFFF_FFFF)) begin
      stallCountQ <= stallCountQ + 32'd1;
    end
  end

  assign StallCount = stallCountQ;
`endif

endmodule

// File: tb/tb_sad_hazard_scoreboard.sv
// Self-checking bench for sad_hazard_scoreboard: ready-time model plus directed scenarios.
module tb_sad_hazard_scoreboard;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       IdValid = 1'b0;
  logic [4:0] IdRs = '0, IdRt = '0, IdRd = '0;
  logic       IdRsUsed = 1'b0, IdRtUsed = 1'b0, IdRegWrite = 1'b0;
  logic       IdIsLoad = 1'b0, IdIsSAD = 1'b0, Flush = 1'b0;
  logic [4:0] MEMrd = '0, SAD1rd = '0, SAD2rd = '0, SAD3rd = '0;
  logic       MEMRegWrite = 1'b0, SAD1RegWrite = 1'b0, SAD2RegWrite = 1'b0, SAD3RegWrite = 1'b0;
  logic       Stall, Issue;
  logic [2:0] FwdA, FwdB;
`ifdef SAD_STALL_COUNT_EN
  logic [31:0] StallCount;
`endif

  int checks = 0;
  int errors = 0;

  sad_hazard_scoreboard dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .IdValid      (IdValid),
    .IdRs         (IdRs),
    .IdRt         (IdRt),
    .IdRsUsed     (IdRsUsed),
    .IdRtUsed     (IdRtUsed),
    .IdRd         (IdRd),
    .IdRegWrite   (IdRegWrite),
    .IdIsLoad     (IdIsLoad),
    .IdIsSAD      (IdIsSAD),
    .Flush        (Flush),
    .MEMrd        (MEMrd),
    .SAD1rd       (SAD1rd),
    .SAD2rd       (SAD2rd),
    .SAD3rd       (SAD3rd),
    .MEMRegWrite  (MEMRegWrite),
    .SAD1RegWrite (SAD1RegWrite),
    .SAD2RegWrite (SAD2RegWrite),
    .SAD3RegWrite (SAD3RegWrite),
`ifdef SAD_STALL_COUNT_EN
    .StallCount   (StallCount),
`endif
    .Stall        (Stall),
    .Issue        (Issue),
    .FwdA         (FwdA),
    .FwdB         (FwdB)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each register carries the cycle number at which its value becomes forwardable.
  longint unsigned readyAt [32];
  longint unsigned cyc = 0;
  bit              mExValid = 1'b0;
  bit [4:0]        mExRs = '0, mExRt = '0;
  bit [31:0]       mStallCount = '0;

  function automatic bit notReady(input logic [4:0] r);
    return (r != 0) && (readyAt[r] > cyc);
  endfunction

  function automatic bit mHazard();
    return (IdRsUsed && notReady(IdRs)) || (IdRtUsed && notReady(IdRt)) ||
           (IdRegWrite && notReady(IdRd));
  endfunction

  function automatic bit mStall();
    return IdValid && !Flush && mHazard();
  endfunction

  function automatic bit mIssue();
    return IdValid && !Flush && !mHazard();
  endfunction

  function automatic longint unsigned mLat();
    if (IdIsSAD) return 4;
    if (IdIsLoad) return 1;
    return 0;
  endfunction

  function automatic logic [2:0] mFwd(input bit [4:0] src);
    logic [4:0] rds [4];
    logic       wes [4];
    rds[0] = MEMrd;  rds[1] = SAD1rd;  rds[2] = SAD2rd;  rds[3] = SAD3rd;
    wes[0] = MEMRegWrite; wes[1] = SAD1RegWrite; wes[2] = SAD2RegWrite; wes[3] = SAD3RegWrite;
    if (!mExValid || src == 0) return 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (wes[k] && rds[k] == src) return 3'(k + 1);
    end
    return 3'd0;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) readyAt[i] <= 0;
      cyc         <= 0;
      mExValid    <= 1'b0;
      mExRs       <= '0;
      mExRt       <= '0;
      mStallCount <= '0;
    end else begin
      if (mIssue() && IdRegWrite && IdRd != 0) readyAt[IdRd] <= cyc + 1 + mLat();
      if (mStall() && mStallCount != 32'hFFFF_FFFF) mStallCount <= mStallCount + 1;
      mExValid <= mIssue();
      mExRs    <= IdRsUsed ? IdRs : 5'd0;
      mExRt    <= IdRtUsed ? IdRt : 5'd0;
      cyc      <= cyc + 1;
    end
  end

  always @(negedge Clk) begin
    check("cmp_stall", {31'd0, Stall}, {31'd0, mStall()});
    check("cmp_issue", {31'd0, Issue}, {31'd0, mIssue()});
    check("cmp_fwdA", {29'd0, FwdA}, {29'd0, mFwd(mExRs)});
    check("cmp_fwdB", {29'd0, FwdB}, {29'd0, mFwd(mExRt)});
`ifdef SAD_STALL_COUNT_EN
    check("cmp_stallCount", StallCount, mStallCount);
`endif
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic setId(input bit v, input logic [4:0] rs, input bit rsU, input logic [4:0] rt,
                       input bit rtU, input logic [4:0] rd, input bit we, input bit ld,
                       input bit sad);
    IdValid = v;  IdRs = rs;  IdRsUsed = rsU;  IdRt = rt;  IdRtUsed = rtU;
    IdRd = rd;  IdRegWrite = we;  IdIsLoad = ld;  IdIsSAD = sad;
  endtask

  task automatic clrStages();
    MEMrd = '0;  SAD1rd = '0;  SAD2rd = '0;  SAD3rd = '0;
    MEMRegWrite = 1'b0;  SAD1RegWrite = 1'b0;  SAD2RegWrite = 1'b0;  SAD3RegWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clrStages();
    repeat (n) step();
  endtask

  // Counts stall cycles until the held ID instruction issues, then clocks it into EX.
  task automatic waitIssue(input string name, input int expStalls);
    int n = 0;
    bit got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (Issue) begin
        got = 1'b1;
        break;
      end
      n++;
      step();
    end
    check({name, "_issued"}, {31'd0, got}, 32'd1);
    check({name, "_stalls"}, n, expStalls);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    setId(1, 7, 1, 7, 1, 7, 1, 0, 1);
    #3;
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_issue", {31'd0, Issue}, 32'd1);
    check("rst_fwdA", {29'd0, FwdA}, 32'd0);
    idle(2);
    Reset = 1'b1;
    idle(2);

    // ALU producer: no stall, then MEM forward (beats SAD2 with same rd).
    setId(1, 0, 0, 0, 0, 3, 1, 0, 0);
    waitIssue("alu_prod", 0);
    setId(1, 3, 1, 0, 0, 0, 0, 0, 0);
    waitIssue("alu_cons", 0);
    MEMrd = 3;  MEMRegWrite = 1'b1;  SAD2rd = 3;  SAD2RegWrite = 1'b1;
    #1;
    check("alu_fwdA", {29'd0, FwdA}, 32'd1);
    idle(6);

    // Load producer: one stall, then SAD1 forward on source B.
    setId(1, 0, 0, 0, 0, 4, 1, 1, 0);
    waitIssue("load_prod", 0);
    setId(1, 0, 0, 4, 1, 0, 0, 0, 0);
    waitIssue("load_cons", 1);
    SAD1rd = 4;  SAD1RegWrite = 1'b1;
    #1;
    check("load_fwdB", {29'd0, FwdB}, 32'd2);
    check("load_fwdA", {29'd0, FwdA}, 32'd0);
    idle(6);

    // SAD producer (Load flag also set; SAD wins): four RAW stalls.
    setId(1, 0, 0, 0, 0, 8, 1, 1, 1);
    waitIssue("sad_prod", 0);
    setId(1, 8, 1, 0, 0, 0, 0, 0, 0);
    waitIssue("sad_raw", 4);
    SAD3rd = 8;  SAD3RegWrite = 1'b1;
    #1;
    check("sad_fwdA", {29'd0, FwdA}, 32'd4);
    idle(6);

    // WAW behind a SAD.
    setId(1, 0, 0, 0, 0, 9, 1, 0, 1);
    waitIssue("waw_prod", 0);
    setId(1, 0, 0, 0, 0, 9, 1, 0, 0);
    waitIssue("waw_cons", 4);
    idle(6);

    // r0 never hazards or forwards.
    setId(1, 0, 0, 0, 0, 0, 1, 0, 1);
    waitIssue("r0_prod", 0);
    setId(1, 0, 1, 0, 1, 0, 1, 0, 0);
    waitIssue("r0_cons", 0);
    MEMrd = 0;  MEMRegWrite = 1'b1;
    #1;
    check("r0_fwdA", {29'd0, FwdA}, 32'd0);
    check("r0_fwdB", {29'd0, FwdB}, 32'd0);
    idle(6);

    // Flush hides the stall for one cycle without touching the scoreboard.
    setId(1, 0, 0, 0, 0, 10, 1, 0, 1);
    waitIssue("flush_prod", 0);
    setId(1, 10, 1, 0, 0, 0, 0, 0, 0);
    Flush = 1'b1;
    @(negedge Clk);
    check("flush_stall", {31'd0, Stall}, 32'd0);
    check("flush_issue", {31'd0, Issue}, 32'd0);
    step();
    Flush = 1'b0;
    waitIssue("flush_cons", 3);
    idle(6);

    // Async reset mid-countdown.
    setId(1, 0, 0, 0, 0, 5, 1, 0, 1);
    waitIssue("rst_prod", 0);
    setId(1, 5, 1, 5, 1, 0, 0, 0, 0);
    MEMrd = 5;  MEMRegWrite = 1'b1;
    step();
    check("rst_pre_stall", {31'd0, Stall}, 32'd1);
    #1;
    Reset = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, Stall}, 32'd0);
    check("rst_mid_issue", {31'd0, Issue}, 32'd1);
    check("rst_mid_fwdA", {29'd0, FwdA}, 32'd0);
    check("rst_mid_fwdB", {29'd0, FwdB}, 32'd0);
`ifdef SAD_STALL_COUNT_EN
    check("rst_mid_count", StallCount, 32'd0);
`endif
    step();
    Reset = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
